// File: rtl/id_pkg.sv
// Shared types and helpers for the RV64I decode stage.
// Contents: opcode constants, instruction class enum (4-bit, driven on
// o_ID_class), immediate format enum, default XLEN, and pure decode helpers.
package id_pkg;

  localparam int XLEN_DEF = 64;

  localparam logic [6:0] OPC_ALU_R  = 7'b0110011;
  localparam logic [6:0] OPC_ALU_I  = 7'b0010011;
  localparam logic [6:0] OPC_ALU_RW = 7'b0111011;
  localparam logic [6:0] OPC_ALU_IW = 7'b0011011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_ALU_R   = 4'd1,
    CLS_ALU_I   = 4'd2,
    CLS_ALU_RW  = 4'd3,
    CLS_ALU_IW  = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_BRANCH  = 4'd7,
    CLS_JAL     = 4'd8,
    CLS_JALR    = 4'd9,
    CLS_LUI     = 4'd10,
    CLS_AUIPC   = 4'd11,
    CLS_SYSTEM  = 4'd12
  } inst_class_e;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_e;

  // Compressed/reserved encodings (low bits != 11) are never legal here.
  function automatic inst_class_e decode_class(input logic [31:0] inst);
    inst_class_e cls;
    cls = CLS_ILLEGAL;
    if (inst[1:0] != 2'b11) begin
      cls = CLS_ILLEGAL;
    end else begin
      case (inst[6:0])
        OPC_ALU_R:  cls = CLS_ALU_R;
        OPC_ALU_I:  cls = CLS_ALU_I;
        OPC_ALU_RW: cls = CLS_ALU_RW;
        OPC_ALU_IW: cls = CLS_ALU_IW;
        OPC_LOAD:   cls = CLS_LOAD;
        OPC_STORE:  cls = CLS_STORE;
        OPC_BRANCH: cls = CLS_BRANCH;
        OPC_JAL:    cls = CLS_JAL;
        OPC_JALR:   cls = CLS_JALR;
        OPC_LUI:    cls = CLS_LUI;
        OPC_AUIPC:  cls = CLS_AUIPC;
        OPC_SYSTEM: cls = CLS_SYSTEM;
        default:    cls = CLS_ILLEGAL;
      endcase
    end
    return cls;
  endfunction

  // SYSTEM uses the I layout (CSR address lives in inst[31:20]).
  function automatic imm_fmt_e class_fmt(input inst_class_e cls);
    imm_fmt_e fmt;
    case (cls)
      CLS_ALU_I, CLS_ALU_IW, CLS_LOAD, CLS_JALR, CLS_SYSTEM: fmt = FMT_I;
      CLS_STORE:            fmt = FMT_S;
      CLS_BRANCH:           fmt = FMT_B;
      CLS_LUI, CLS_AUIPC:   fmt = FMT_U;
      CLS_JAL:              fmt = FMT_J;
      default:              fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/id_inst_queue.sv
// DEPTH-entry FIFO of fetched {inst, pc} beats feeding the decoder.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_push with
// i_push_inst/i_push_pc enqueue; i_pop dequeues the head; i_flush empties
// the queue; o_head_inst/o_head_pc show the head; o_count/o_empty status.
module id_inst_queue
  import id_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = XLEN_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [31:0]              i_push_inst,
  input  logic [XLEN-1:0]          i_push_pc,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [31:0]              o_head_inst,
  output logic [XLEN-1:0]          o_head_pc,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]     r_inst_mem [DEPTH];
  logic [XLEN-1:0] r_pc_mem   [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  // Entry storage; written at the tail on every accepted push.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_inst_mem[i] <= 32'd0;
        r_pc_mem[i]   <= {XLEN{1'b0}};
      end
    end else if (i_push && !i_flush) begin
      r_inst_mem[r_wptr] <= i_push_inst;
      r_pc_mem[r_wptr]   <= i_push_pc;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else if (i_flush) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (i_push) r_wptr <= r_wptr + PW'(1'b1);
      if (i_pop)  r_rptr <= r_rptr + PW'(1'b1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1'b1);
        2'b01:   r_count <= r_count - CW'(1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_inst = r_inst_mem[r_rptr];
  assign o_head_pc   = r_pc_mem[r_rptr];
  assign o_count     = r_count;
  assign o_empty     = (r_count == {CW{1'b0}});

endmodule

// File: rtl/id_stage.sv
// RV64I decode stage between instruction fetch and EX.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_inst_valid,
// i_inst, i_inst_addr fetch beat; i_flush EX jump redirect; i_EX_ready
// downstream accept; o_stall backpressure to fetch; o_ID_* registered
// decoded bundle (valid, pc, class, rd, rs1, rs2, funct3, funct7, imm,
// illegal).
module id_stage
  import id_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = XLEN_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_inst_valid,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_inst_addr,
  input  logic            i_flush,
  input  logic            i_EX_ready,
  output logic            o_stall,
  output logic            o_ID_valid,
  output logic [XLEN-1:0] o_ID_pc,
  output logic [3:0]      o_ID_class,
  output logic [4:0]      o_ID_rd,
  output logic [4:0]      o_ID_rs1,
  output logic [4:0]      o_ID_rs2,
  output logic [2:0]      o_ID_funct3,
  output logic [6:0]      o_ID_funct7,
  output logic [XLEN-1:0] o_ID_imm,
  output logic            o_ID_illegal
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic            w_free, w_pop, w_bypass, w_push, w_q_empty, w_q_full;
  logic [CW-1:0]   w_q_count;
  logic [31:0]     w_head_inst, w_dec_inst;
  logic [XLEN-1:0] w_head_pc, w_dec_pc, w_dec_imm;
  inst_class_e     w_dec_class;
  imm_fmt_e        w_dec_fmt;

  logic            r_valid, r_illegal;
  logic [XLEN-1:0] r_pc, r_imm;
  logic [3:0]      r_class;
  logic [4:0]      r_rd, r_rs1, r_rs2;
  logic [2:0]      r_funct3;
  logic [6:0]      r_funct7;

  // Output slot can take a new bundle when empty or being consumed this cycle.
  assign w_free    = !r_valid || i_EX_ready;
  assign w_pop     = !w_q_empty && w_free;
  assign w_q_full  = (w_q_count == CW'(DEPTH));
  assign o_stall   = w_q_full && !w_pop;
  // Bypass skips the queue only when nothing older is waiting in it.
  assign w_bypass  = w_q_empty && w_free && i_inst_valid;
  assign w_push    = i_inst_valid && !w_bypass && !o_stall && !i_flush;

  id_inst_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) u_queue (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (w_push),
    .i_push_inst (i_inst),
    .i_push_pc   (i_inst_addr),
    .i_pop       (w_pop && !i_flush),
    .i_flush     (i_flush),
    .o_head_inst (w_head_inst),
    .o_head_pc   (w_head_pc),
    .o_count     (w_q_count),
    .o_empty     (w_q_empty)
  );

  // Select the beat being loaded: queue head has priority over the live beat.
  always_comb begin
    w_dec_inst = i_inst;
    w_dec_pc   = i_inst_addr;
    if (w_pop) begin
      w_dec_inst = w_head_inst;
      w_dec_pc   = w_head_pc;
    end else begin
      w_dec_inst = i_inst;
      w_dec_pc   = i_inst_addr;
    end
  end

  assign w_dec_class = decode_class(w_dec_inst);
  assign w_dec_fmt   = class_fmt(w_dec_class);

  // Immediate assembly, sign bit inst[31] replicated up to XLEN.
  always_comb begin
    w_dec_imm = {XLEN{1'b0}};
    case (w_dec_fmt)
      FMT_I: w_dec_imm = {{(XLEN-12){w_dec_inst[31]}}, w_dec_inst[31:20]};
      FMT_S: w_dec_imm = {{(XLEN-12){w_dec_inst[31]}}, w_dec_inst[31:25],
                          w_dec_inst[11:7]};
      FMT_B: w_dec_imm = {{(XLEN-13){w_dec_inst[31]}}, w_dec_inst[31],
                          w_dec_inst[7], w_dec_inst[30:25], w_dec_inst[11:8], 1'b0};
      FMT_U: w_dec_imm = {{(XLEN-32){w_dec_inst[31]}}, w_dec_inst[31:12], 12'h000};
      FMT_J: w_dec_imm = {{(XLEN-21){w_dec_inst[31]}}, w_dec_inst[31],
                          w_dec_inst[19:12], w_dec_inst[20], w_dec_inst[30:21], 1'b0};
      default: w_dec_imm = {XLEN{1'b0}};
    endcase
  end

  // Output bundle register; flush wins over any load or handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid   <= 1'b0;
      r_pc      <= {XLEN{1'b0}};
      r_class   <= 4'd0;
      r_rd      <= 5'd0;
      r_rs1     <= 5'd0;
      r_rs2     <= 5'd0;
      r_funct3  <= 3'd0;
      r_funct7  <= 7'd0;
      r_imm     <= {XLEN{1'b0}};
      r_illegal <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_pop || w_bypass) begin
      r_valid   <= 1'b1;
      r_pc      <= w_dec_pc;
      r_class   <= w_dec_class;
      r_rd      <= w_dec_inst[11:7];
      r_rs1     <= w_dec_inst[19:15];
      r_rs2     <= w_dec_inst[24:20];
      r_funct3  <= w_dec_inst[14:12];
      r_funct7  <= w_dec_inst[31:25];
      r_imm     <= w_dec_imm;
      r_illegal <= (w_dec_class == CLS_ILLEGAL);
    end else if (i_EX_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_ID_valid   = r_valid;
  assign o_ID_pc      = r_pc;
  assign o_ID_class   = r_class;
  assign o_ID_rd      = r_rd;
  assign o_ID_rs1     = r_rs1;
  assign o_ID_rs2     = r_rs2;
  assign o_ID_funct3  = r_funct3;
  assign o_ID_funct7  = r_funct7;
  assign o_ID_imm     = r_imm;
  assign o_ID_illegal = r_illegal;

endmodule
